// File: rtl/io_bus_pkg.sv
// Shared constants, address map and enums for the CPU memory/I-O bus controller.
// ADDR_KEY_EDGE only decodes when the top is built with KEY_EDGE_EN.
package io_bus_pkg;

  localparam int DATA_W      = 32;
  localparam int DMEM_ADDR_W = 13;
  localparam int DMEM_WORD_W = 2;

  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;
  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;

  localparam logic [31:0] ADDR_HEX      = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR     = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG     = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY      = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW       = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEY_EDGE = 32'hF000_0018;

  typedef enum logic [1:0] {IDLE, DMEM_RD, RESP} state_e;

  typedef enum logic [2:0] {
    TGT_DMEM, TGT_HEX, TGT_LEDR, TGT_LEDG, TGT_KEY, TGT_SW, TGT_KEYEDGE, TGT_NONE
  } tgt_e;

endpackage

// File: rtl/io_sync.sv
// Two-flop synchronizer for asynchronous board inputs; 2-cycle latency, no backpressure.
// Reset value is a parameter so idle-high inputs (keys) come out of reset released.
module io_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU load/store controller for DMEM and board I/O; ack 1 cycle after accept (2 for DMEM load).
// One request at a time: cpu_req is held until cpu_ack. KEY_EDGE_EN adds the sticky key-press register.
module io_bus_ctrl import io_bus_pkg::*; #(
  parameter int DBITS        = DATA_W,
  parameter int DMEMADDRBITS = DMEM_ADDR_W,
  parameter int DMEMWORDBITS = DMEM_WORD_W
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cpu_req,
  input  logic                                 cpu_we,
  input  logic [DBITS-1:0]                     cpu_addr,
  input  logic [DBITS-1:0]                     cpu_wdata,
  output logic                                 cpu_ack,
  output logic [DBITS-1:0]                     cpu_rdata,
  output logic                                 dmem_en,
  output logic                                 dmem_we,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dmem_addr,
  output logic [DBITS-1:0]                     dmem_wdata,
  input  logic [DBITS-1:0]                     dmem_rdata,
  input  logic [KEY_W-1:0]                     key_in,
  input  logic [SW_W-1:0]                      sw_in,
  output logic [HEX_W-1:0]                     hex_out,
  output logic [LEDR_W-1:0]                    ledr_out,
  output logic [LEDG_W-1:0]                    ledg_out
);

  logic [KEY_W-1:0] key_sync;
  logic [KEY_W-1:0] key_pressed;
  logic [SW_W-1:0]  sw_sync;
  logic [KEY_W-1:0] key_edge;
  logic [DBITS-1:0] word_addr;
  logic [DBITS-1:0] io_rdata;
  logic             accept;
  logic             unused_addr_bits;
  state_e           state;
  tgt_e             tgt;

  io_sync #(.W(KEY_W), .RST_VAL({KEY_W{1'b1}})) u_key_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (key_in),
    .q       (key_sync)
  );

  io_sync #(.W(SW_W), .RST_VAL('0)) u_sw_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw_in),
    .q       (sw_sync)
  );

  // Byte-offset bits are ignored everywhere; I/O registers match on the aligned word.
  assign word_addr        = {cpu_addr[DBITS-1:DMEMWORDBITS], DMEMWORDBITS'(0)};
  assign unused_addr_bits = ^cpu_addr[DMEMWORDBITS-1:0];
  assign key_pressed      = ~key_sync;

  always_comb begin
    tgt = TGT_NONE;
    if (cpu_addr[DBITS-1:DMEMADDRBITS] == '0)       tgt = TGT_DMEM;
    else if (word_addr == DBITS'(ADDR_HEX))         tgt = TGT_HEX;
    else if (word_addr == DBITS'(ADDR_LEDR))        tgt = TGT_LEDR;
    else if (word_addr == DBITS'(ADDR_LEDG))        tgt = TGT_LEDG;
    else if (word_addr == DBITS'(ADDR_KEY))         tgt = TGT_KEY;
    else if (word_addr == DBITS'(ADDR_SW))          tgt = TGT_SW;
`ifdef KEY_EDGE_EN
    else if (word_addr == DBITS'(ADDR_KEY_EDGE))    tgt = TGT_KEYEDGE;
`endif
  end

  assign accept = (state == IDLE) && cpu_req;

  // DMEM is strobed combinationally in the accept cycle so read data lands in DMEM_RD.
  assign dmem_en    = accept && (tgt == TGT_DMEM) && reset_n;
  assign dmem_we    = dmem_en && cpu_we;
  assign dmem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
  assign dmem_wdata = cpu_wdata;

`ifdef KEY_EDGE_EN
  logic [KEY_W-1:0] key_prev;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_clr;

  assign key_press = key_prev & ~key_sync;
  assign key_clr   = (accept && cpu_we && (tgt == TGT_KEYEDGE)) ? cpu_wdata[KEY_W-1:0] : '0;

  // Set is OR'd after the clear mask so a simultaneous press survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev <= '1;
      key_edge <= '0;
    end else begin
      key_prev <= key_sync;
      key_edge <= (key_edge & ~key_clr) | key_press;
    end
  end
`else
  assign key_edge = '0;
`endif

  always_comb begin
    io_rdata = '0;
    case (tgt)
      TGT_HEX:     io_rdata = DBITS'(hex_out);
      TGT_LEDR:    io_rdata = DBITS'(ledr_out);
      TGT_LEDG:    io_rdata = DBITS'(ledg_out);
      TGT_KEY:     io_rdata = DBITS'(key_pressed);
      TGT_SW:      io_rdata = DBITS'(sw_sync);
      TGT_KEYEDGE: io_rdata = DBITS'(key_edge);
      default:     io_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      hex_out   <= '0;
      ledr_out  <= '0;
      ledg_out  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (tgt == TGT_DMEM) begin
              state   <= cpu_we ? RESP : DMEM_RD;
              cpu_ack <= cpu_we;
            end else begin
              state   <= RESP;
              cpu_ack <= 1'b1;
              if (cpu_we) begin
                case (tgt)
                  TGT_HEX:  hex_out  <= cpu_wdata[HEX_W-1:0];
                  TGT_LEDR: ledr_out <= cpu_wdata[LEDR_W-1:0];
                  TGT_LEDG: ledg_out <= cpu_wdata[LEDG_W-1:0];
                  default:  ;
                endcase
              end else begin
                cpu_rdata <= io_rdata;
              end
            end
          end
        end
        DMEM_RD: begin
          cpu_rdata <= dmem_rdata;
          cpu_ack   <= 1'b1;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: scoreboard of expected ack latency/read data per access.
// Build with +define+KEY_EDGE_EN to also exercise the sticky key-press register.
module tb_io_bus_ctrl;
  import io_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dmem_en;
  logic        dmem_we;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic [3:0]  key_in = 4'hF;
  logic [9:0]  sw_in = '0;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic [7:0]  ledg_out;

  always #5 clk = ~clk;

  io_bus_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .key_in     (key_in),
    .sw_in      (sw_in),
    .hex_out    (hex_out),
    .ledr_out   (ledr_out),
    .ledg_out   (ledg_out)
  );

  // Synchronous DMEM: read data appears the cycle after the strobe.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (dmem_en) begin
      if (dmem_we) mem[dmem_addr] <= dmem_wdata;
      dmem_rdata <= mem[dmem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int          obs_lat;
  logic [31:0] obs_rd;
  logic        obs_en, obs_we, obs_extra_en;
  logic [10:0] obs_addr;

  // Drives one access and records what the DUT did; comparisons live in the tests.
  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    obs_en = dmem_en; obs_we = dmem_we; obs_addr = dmem_addr;
    obs_extra_en = 1'b0;
    obs_lat = -1;
    obs_rd = 'x;
    @(posedge clk);
    #1 cpu_req = 1'b0; cpu_we = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dmem_en) obs_extra_en = 1'b1;
      if (cpu_ack) begin
        obs_lat = i;
        obs_rd = cpu_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h100;
    repeat (3) @(negedge clk);
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", cpu_ack); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    checks++; if (dmem_en !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("FAIL reset_dmem: got en=%b we=%b expected 0", dmem_en, dmem_we); end
    checks++; if ({hex_out, ledr_out, ledg_out} !== '0) begin failures++; $display("FAIL reset_regs: got %h/%h/%h expected 0", hex_out, ledr_out, ledg_out); end
    cpu_req = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY, '0);
    begin
      exp_t e = exp_q.pop_front();
      checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL reset_key_released: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    end
  endtask

  task automatic test_dmem();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b0, lat: 1});
    bus_xfer(1'b1, 32'h100, 32'hDEADBEEF);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL dmem_store_lat: got %0d expected %0d", obs_lat, e.lat); end
    checks++; if (obs_en !== 1'b1 || obs_we !== 1'b1 || obs_addr !== 11'h40) begin failures++; $display("FAIL dmem_store_strobe: got en=%b we=%b addr=%h expected 1 1 040", obs_en, obs_we, obs_addr); end
    checks++; if (obs_extra_en !== 1'b0) begin failures++; $display("FAIL dmem_store_en_in_resp: got %b expected 0", obs_extra_en); end
    exp_q.push_back('{rdata: 32'hDEADBEEF, chk_rd: 1'b1, lat: 2});
    bus_xfer(1'b0, 32'h100, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL dmem_load: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    checks++; if (obs_en !== 1'b1 || obs_we !== 1'b0 || obs_addr !== 11'h40) begin failures++; $display("FAIL dmem_load_strobe: got en=%b we=%b addr=%h expected 1 0 040", obs_en, obs_we, obs_addr); end
    // Top word of DMEM, with nonzero byte-offset bits that must be ignored.
    bus_xfer(1'b1, 32'h1FFF, 32'h12345678);
    exp_q.push_back('{rdata: 32'h12345678, chk_rd: 1'b1, lat: 2});
    bus_xfer(1'b0, 32'h1FFC, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata || obs_addr !== 11'h7FF) begin failures++; $display("FAIL dmem_top_word: got lat=%0d rd=%h addr=%h expected lat=%0d rd=%h addr=7ff", obs_lat, obs_rd, obs_addr, e.lat, e.rdata); end
  endtask

  task automatic test_io_regs();
    logic        we_t [4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] addr_t [4] = '{ADDR_HEX, ADDR_LEDR, ADDR_HEX, ADDR_LEDR};
    logic [31:0] wd_t [4]   = '{32'h0000ABCD, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] rd_t [4]   = '{32'h0, 32'h0, 32'h0000ABCD, 32'h000003FF};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      exp_q.push_back('{rdata: rd_t[i], chk_rd: !we_t[i], lat: 1});
      bus_xfer(we_t[i], addr_t[i], wd_t[i]);
      e = exp_q.pop_front();
      checks++; if (obs_lat !== e.lat || obs_en !== 1'b0 || (e.chk_rd && obs_rd !== e.rdata)) begin failures++; $display("FAIL io_access_%0d: got lat=%0d en=%b rd=%h expected lat=%0d en=0 rd=%h", i, obs_lat, obs_en, obs_rd, e.lat, e.rdata); end
    end
    checks++; if (hex_out !== 16'hABCD) begin failures++; $display("FAIL hex_out: got %h expected abcd", hex_out); end
    checks++; if (ledr_out !== 10'h3FF) begin failures++; $display("FAIL ledr_out: got %h expected 3ff", ledr_out); end
  endtask

  task automatic test_sync();
    exp_t e;
    @(negedge clk) sw_in = 10'h155; key_in = 4'b1010;
    repeat (3) @(posedge clk);
    exp_q.push_back('{rdata: 32'h155, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_SW, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL sw_read: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    exp_q.push_back('{rdata: 32'h5, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL key_read: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    // Writes to read-only status are acked and dropped.
    bus_xfer(1'b1, ADDR_SW, 32'hFFFFFFFF);
    checks++; if (obs_lat !== 1 || hex_out !== 16'hABCD || ledr_out !== 10'h3FF) begin failures++; $display("FAIL sw_write_dropped: got lat=%0d hex=%h ledr=%h expected 1 abcd 3ff", obs_lat, hex_out, ledr_out); end
    @(negedge clk) key_in = 4'hF;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_unmapped();
    exp_t e;
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, 32'hF0000020, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata || obs_en !== 1'b0) begin failures++; $display("FAIL unmapped_load: got lat=%0d rd=%h en=%b expected lat=%0d rd=%h en=0", obs_lat, obs_rd, obs_en, e.lat, e.rdata); end
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b0, lat: 1});
    bus_xfer(1'b1, 32'h80000000, 32'hFFFFFFFF);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_en !== 1'b0 || obs_extra_en !== 1'b0) begin failures++; $display("FAIL unmapped_store: got lat=%0d en=%b expected lat=%0d en=0", obs_lat, obs_en, e.lat); end
    checks++; if (hex_out !== 16'hABCD || ledr_out !== 10'h3FF || ledg_out !== 8'h00) begin failures++; $display("FAIL unmapped_no_side_effect: got %h/%h/%h expected abcd/3ff/00", hex_out, ledr_out, ledg_out); end
`ifndef KEY_EDGE_EN
    bus_xfer(1'b0, ADDR_HEX, '0);
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY_EDGE, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL keyedge_unmapped: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
`endif
  endtask

`ifdef KEY_EDGE_EN
  task automatic test_key_edge();
    exp_t e;
    @(negedge clk) key_in = 4'b1011;
    repeat (4) @(posedge clk);
    exp_q.push_back('{rdata: 32'h4, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY_EDGE, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL keyedge_set: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    bus_xfer(1'b1, ADDR_KEY_EDGE, 32'h4);
    exp_q.push_back('{rdata: 32'h0, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY_EDGE, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL keyedge_clear: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    @(negedge clk) key_in = 4'hF;
    repeat (4) @(posedge clk);
    // Press lands in the synchronizer output exactly when the clear is accepted.
    @(negedge clk) key_in = 4'b1011;
    @(posedge clk);
    @(posedge clk);
    bus_xfer(1'b1, ADDR_KEY_EDGE, 32'h4);
    exp_q.push_back('{rdata: 32'h4, chk_rd: 1'b1, lat: 1});
    bus_xfer(1'b0, ADDR_KEY_EDGE, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL keyedge_set_wins: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
    @(negedge clk) key_in = 4'hF;
    repeat (4) @(posedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    int   ack_seen;
    bus_xfer(1'b1, ADDR_LEDG, 32'h000000FF);
    checks++; if (ledg_out !== 8'hFF) begin failures++; $display("FAIL ledg_write: got %h expected ff", ledg_out); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    ack_seen = 0;
    #1;
    checks++; if (ledg_out !== 8'h00) begin failures++; $display("FAIL reset_mid_ledg: got %h expected 00", ledg_out); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cpu_ack) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin failures++; $display("FAIL reset_mid_no_ack: got %0d acks expected 0", ack_seen); end
    reset_n = 1'b1;
    exp_q.push_back('{rdata: 32'hDEADBEEF, chk_rd: 1'b1, lat: 2});
    bus_xfer(1'b0, 32'h100, '0);
    e = exp_q.pop_front();
    checks++; if (obs_lat !== e.lat || obs_rd !== e.rdata) begin failures++; $display("FAIL reset_mid_recover: got lat=%0d rd=%h expected lat=%0d rd=%h", obs_lat, obs_rd, e.lat, e.rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dmem();
    test_io_regs();
    test_sync();
    test_unmapped();
`ifdef KEY_EDGE_EN
    test_key_edge();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Memory/I-O bus controller between the CPU data port and the resources behind it: data memory (DMEM) and the memory-mapped board I/O (HEX, LEDR, LEDG, KEY, SW).
- Accepts one CPU load/store at a time over a req/ack handshake, decodes the address, and sequences the synchronous DMEM.
- Owns the output device registers and synchronizes board inputs.
- Instantiated in the top level on the PLL clock.

Parameters:
- DBITS, 32, data/address width
- DMEMADDRBITS, 13, byte-address bits covering DMEM
- DMEMWORDBITS, 2, byte-offset bits within a word
- ADDR_HEX, 32'hF0000000, HEX display register
- ADDR_LEDR, 32'hF0000004, red LED register
- ADDR_LEDG, 32'hF0000008, green LED register
- ADDR_KEY, 32'hF0000010, key status (read-only)
- ADDR_SW, 32'hF0000014, switch status (read-only)

Ports:
- clk  in  1  PLL clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held with stable addr/we/wdata until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  DBITS  byte address (word aligned; bits [1:0] ignored)
- cpu_wdata  in  DBITS  store data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DBITS  load data, valid when cpu_ack=1, held until next ack
- dmem_en  out  1  DMEM access strobe
- dmem_we  out  1  DMEM write enable
- dmem_addr  out  DMEMADDRBITS-DMEMWORDBITS  word address
- dmem_wdata  out  DBITS  DMEM write data
- dmem_rdata  in  DBITS  DMEM read data, one cycle after dmem_en
- key_in  in  4  raw board keys, active-low, asynchronous
- sw_in  in  10  raw switches, asynchronous
- hex_out  out  16  four 4-bit digits; seven-segment decode is external
- ledr_out  out  10  red LEDs
- ledg_out  out  8  green LEDs

Behaviour:
- Reset: state IDLE; cpu_ack=0, cpu_rdata=0, dmem_en=0, dmem_we=0; hex_out, ledr_out and ledg_out all 0; synchronizer flops 0 for SW and 1 for KEY (keys released).
- Address decode:
  - DMEM when cpu_addr[DBITS-1:DMEMADDRBITS]==0.
  - I/O register on an exact match with one of the ADDR_* values.
  - Anything else is unmapped.
- FSM states IDLE, DMEM_RD, RESP.
  - IDLE & cpu_req, DMEM store: dmem_en=dmem_we=1 that cycle → RESP.
  - IDLE & cpu_req, DMEM load: dmem_en=1, dmem_we=0 → DMEM_RD.
  - IDLE & cpu_req, I/O or unmapped access: register effect applied on that edge → RESP.
  - DMEM_RD: capture dmem_rdata into cpu_rdata → RESP.
  - RESP: cpu_ack=1 for exactly one cycle → IDLE.
  - No new request is accepted in RESP. A cpu_req still high in the cycle after the ack is treated as a new request.
- Latency, accept to ack: store or I/O access = 1 cycle; DMEM load = 2 cycles.
- I/O writes:
  - HEX takes wdata[15:0]; LEDR takes wdata[9:0]; LEDG takes wdata[7:0].
  - Writes to KEY or SW are dropped but still acked.
- I/O reads, zero-extended:
  - HEX/LEDR/LEDG return the current register value.
  - KEY returns ~key_sync (1 = pressed).
  - SW returns sw_sync.
- Unmapped access: write dropped, read returns 0, ack normal.
- KEY and SW each pass through a 2-flop synchronizer. A read samples the synchronized value on the accept edge.
- Reset asserted mid-transaction: immediate return to IDLE; no ack; outputs take reset values. A DMEM write already strobed may complete.
- dmem_en is asserted only in the accept cycle, never in RESP.

Optional Feature:
- Macro KEY_EDGE_EN.
- When defined:
  - Adds a sticky register key_edge[3:0] at 32'hF0000018.
  - A bit sets on a synchronized press (key_sync goes 1→0).
  - Read returns key_edge.
  - Write clears the bits where wdata[3:0]=1 (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Reset value 0.
- When undefined: 32'hF0000018 is unmapped; no edge logic is built.

Decomposition:
- Package io_bus_pkg holds:
  - ADDR_* constants plus ADDR_KEY_EDGE
  - state enum {IDLE, DMEM_RD, RESP}
  - decode-target enum {TGT_DMEM, TGT_HEX, TGT_LEDR, TGT_LEDG, TGT_KEY, TGT_SW, TGT_KEYEDGE, TGT_NONE}
  - width constants
- One sub-module, io_sync: parameterized-width 2-flop synchronizer with a reset value parameter, used for both KEY and SW.

Test Plan:
- Store 32'hDEADBEEF to 0x100, then load 0x100 → dmem_addr=0x40 with dmem_we pulse; store acked 1 cycle after accept; load acked 2 cycles after accept with cpu_rdata=32'hDEADBEEF.
- Store 32'h0000ABCD to ADDR_HEX and 32'hFFFFFFFF to ADDR_LEDR, then read both back → hex_out=16'hABCD, ledr_out=10'h3FF; reads return 32'h0000ABCD and 32'h000003FF.
- sw_in=10'h155, key_in=4'b1010, wait 3 cycles, then read SW and KEY → 32'h155 and 32'h5.
- Load from 32'hF0000020 and store to 32'h80000000 → both acked; read returns 0; no dmem_en; no register changes.
- Assert reset_n=0 in DMEM_RD after LEDG=8'hFF was written → cpu_ack stays 0, ledg_out=0; after release, a new request completes normally.
- With KEY_EDGE_EN: press KEY[2] (key_in 1→0) → reading 32'hF0000018 returns 4'b0100; write 4'b0100 → reads 0; a press in the same cycle as the clear leaves the bit set.
